instr_fetch: RTL

Instruction fetch stage of the Logo processor. Drives the synchronous instruction ROM and holds a program counter. Delivers `{pc, instruction}` pairs to decode, where bits [31:27] feed `instControl`. It absorbs decode stalls with a one-entry skid buffer and discards wrong-path fetches on a branch or jump redirect from execute.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_skid.sv | 47 ++++
 rtl/instr_fetch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared ISA definitions for the Logo fetch stage: opcode field bounds,
// default widths, the NOP encoding and the output-register source select.
package instr_fetch_pkg;

  localparam int unsigned OPCODE_HI   = 31;
  localparam int unsigned OPCODE_LO   = 27;
  localparam int unsigned PC_W_DEF    = 12;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_IMEM,
    SRC_SKID,
    SRC_EMPTY
  } out_src_e;

endpackage

// File: rtl/instr_fetch_skid.sv
// One-entry skid buffer carrying an {instr, pc} pair, valid/ready on both
// sides, with a synchronous flush that overrides any push.
module fetch_skid
  import instr_fetch_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      instr_q <= in_instr;
      pc_q    <= in_pc;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the synchronous ROM from pc, tags the
// in-flight read, and delivers {pc, instr} to decode through an output
// register backed by a one-entry skid.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_plus1,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [PC_W-1:0]    pc;
  logic               inf_valid;
  logic [PC_W-1:0]    inf_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  logic               sk_valid;
  logic               sk_in_ready;
  logic [INSTR_W-1:0] sk_instr;
  logic [PC_W-1:0]    sk_pc;
  logic               sk_push;
  logic               sk_pop;

  logic               accept;
  logic               out_free;
  logic               issue;
  out_src_e           out_src;

  fetch_skid #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect),
    .in_valid  (sk_push),
    .in_ready  (sk_in_ready),
    .in_instr  (imem_q),
    .in_pc     (inf_pc),
    .out_valid (sk_valid),
    .out_ready (sk_pop),
    .out_instr (sk_instr),
    .out_pc    (sk_pc)
  );

  // Skid drains into the output register ahead of any arriving ROM word so
  // program order is kept; the arriving word then takes the skid slot.
  always_comb begin
    accept   = out_valid && !stall;
    out_free = !out_valid || !stall;
    issue    = !sk_valid && !(out_valid && stall && inf_valid) && !redirect;
    sk_push  = 1'b0;
    sk_pop   = 1'b0;
    out_src  = SRC_HOLD;
    if (inf_valid) begin
      if (out_free) begin
        if (sk_valid) begin
          out_src = SRC_SKID;
          sk_pop  = 1'b1;
          sk_push = 1'b1;
        end else begin
          out_src = SRC_IMEM;
        end
      end else begin
        sk_push = 1'b1;
      end
    end else if (out_free) begin
      if (sk_valid) begin
        out_src = SRC_SKID;
        sk_pop  = 1'b1;
      end else if (accept) begin
        out_src = SRC_EMPTY;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      inf_valid <= 1'b0;
      inf_pc    <= '0;
    end else begin
      inf_valid <= issue;
      if (issue) inf_pc <= pc;
      if (redirect)   pc <= redirect_pc;
      else if (issue) pc <= pc + PC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_instr <= INSTR_W'(NOP_INSTR);
      out_pc    <= '0;
    end else if (redirect) begin
      out_valid <= 1'b0;
    end else begin
      case (out_src)
        SRC_IMEM: begin
          out_valid <= 1'b1;
          out_instr <= imem_q;
          out_pc    <= inf_pc;
        end
        SRC_SKID: begin
          out_valid <= 1'b1;
          out_instr <= sk_instr;
          out_pc    <= sk_pc;
        end
        SRC_EMPTY: out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
    end else if (accept && (fetch_count != '1)) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  skid_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n) !(sk_push && !sk_in_ready && !redirect)
  );

  assign imem_addr   = pc;
  assign if_valid    = out_valid;
  assign if_instr    = out_instr;
  assign if_pc       = out_pc;
  assign if_pc_plus1 = out_pc + PC_W'(1);

endmodule
